// File: rtl/serial_async_rx.sv
// serial_async_rx: UART-style receiver, 1 start, p_WIDTH data (LSB first), 1 stop.
// i_clk/i_reset(async, low) | i_rx line | i_read ack | ov_data, o_full, o_overrun, o_frame_err.
module serial_async_rx #(
  parameter int p_WIDTH  = 8,
  parameter int p_PERIOD = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_read,
  output logic [p_WIDTH-1:0] ov_data,
  output logic               o_full,
  output logic               o_overrun,
  output logic               o_frame_err
);

  localparam int CW = $clog2(p_PERIOD);
  localparam int BW = $clog2(p_WIDTH + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(p_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(p_PERIOD / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(p_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bits;
  logic [p_WIDTH-1:0] shreg;
  logic               rx_m;
  logic               rx_s;
  logic               rx_d;
  logic               done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bits        <= '0;
      shreg       <= '0;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_d        <= 1'b1;
      done        <= 1'b0;
      ov_data     <= '0;
      o_full      <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_m        <= i_rx;
      rx_s        <= rx_m;
      rx_d        <= rx_s;
      done        <= 1'b0;
      o_frame_err <= 1'b0;

      unique case (state)
        IDLE: begin
          // edge, not level: a line stuck low never restarts
          if (rx_d && !rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            bits  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= p_WIDTH'({rx_s, shreg} >> 1);
            bits  <= bits + 1'b1;
            if (bits == BIT_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              done <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // unread word wins over a new one unless it is acked now
      if (done && o_full && !i_read) begin
        o_overrun <= 1'b1;
      end else if (done) begin
        ov_data <= shreg;
        o_full  <= 1'b1;
        if (i_read) begin
          o_overrun <= 1'b0;
        end
      end else if (i_read) begin
        o_full    <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_async_rx.md
SERIAL_ASYNC_RX -- requirements
Module: serial_async_rx

Interface
REQ-001 SHALL have parameter p_WIDTH, default 8, number of data bits per frame (>= 1).
REQ-002 SHALL have parameter p_PERIOD, default 2, clock cycles per bit (>= 2); it matches the transmitter's p_PERIOD.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx  input  1  serial line, asynchronous to i_clk, idle high.
REQ-006 SHALL have port i_read  input  1  consumer acknowledge; clears o_full.
REQ-007 SHALL have port ov_data  output  p_WIDTH  last received data word.
REQ-008 SHALL have port o_full  output  1  ov_data holds an unread word.
REQ-009 SHALL have port o_overrun  output  1  sticky: a word was completed while o_full=1 and no i_read in the same cycle.
REQ-010 SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 SHALL receive frames of 1 start bit (0), p_WIDTH data bits LSB first, 1 stop bit (1), each bit p_PERIOD cycles long.
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all logic uses only the synchronized value (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: on a 1->0 transition of rx_s, SHALL clear the cycle counter and go to START; a line held low SHALL NOT retrigger.
REQ-015 START: after floor(p_PERIOD/2) cycles, SHALL sample rx_s; 0 -> DATA with the counter cleared; 1 -> false start, back to IDLE, no output change.
REQ-016 DATA: SHALL sample rx_s every p_PERIOD cycles (mid-bit) into a shift register, LSB first; after p_WIDTH samples SHALL go to STOP.
REQ-017 STOP: after p_PERIOD cycles, SHALL sample rx_s and return to IDLE.
REQ-018 Stop sample 1: on the next edge, ov_data SHALL load the shift register and o_full SHALL become 1.
REQ-019 Stop sample 0: o_frame_err SHALL pulse 1 for exactly one cycle; ov_data, o_full and o_overrun SHALL be unchanged.
REQ-020 Word completion with o_full=1 and i_read=0 SHALL set o_overrun; ov_data SHALL keep the old (unread) word, and the new word is discarded.
REQ-021 Word completion in the same cycle as i_read=1 SHALL load the new word with o_full staying 1 and no overrun.
REQ-022 i_read=1 with no completion SHALL clear o_full and o_overrun on the next edge; i_read with o_full=0 SHALL have no effect.
REQ-023 The counter width SHALL be $clog2(p_PERIOD), with the wrap at p_PERIOD-1; the bit counter width SHALL be $clog2(p_WIDTH+1).
REQ-024 Latency from the i_rx falling edge to o_full=1 SHALL be 2 + floor(p_PERIOD/2) + (p_WIDTH+1)*p_PERIOD + 1 cycles, with a +-1 cycle synchronizer phase tolerance.
REQ-025 Receive SHALL proceed independently of o_full: a new frame may start while a word is unread.

Reset
REQ-026 On i_reset=0, SHALL take effect immediately (asynchronous): FSM=IDLE, counters=0, synchronizer flops=1, shift register=0.
REQ-027 Reset values SHALL be: ov_data=0, o_full=0, o_overrun=0, o_frame_err=0.
REQ-028 Reset mid-frame SHALL abort the frame with no output update; after release, the block SHALL wait in IDLE for a fresh 1->0 edge.

Verification
REQ-029 Loopback with serial_async_tx (p_WIDTH=8, p_PERIOD=2): send 0xAA+i for i=0..255, pulsing i_read after each o_full -> ov_data equals each sent byte, o_overrun=0, o_frame_err never 1.
REQ-030 Glitch: i_rx low for 1 cycle at p_PERIOD=8 -> START rejects it, FSM back in IDLE, o_full stays 0.
REQ-031 Framing: drive 0x3C with the stop bit forced 0 -> o_frame_err one-cycle pulse, o_full=0, ov_data unchanged.
REQ-032 Overrun: send 0x11 then 0x22 without i_read -> ov_data=0x11, o_full=1, o_overrun=1; i_read -> o_full=0, o_overrun=0.
REQ-033 Simultaneous: i_read asserted in the completion cycle of 0x5A while 0x11 is unread -> ov_data=0x5A, o_full=1, o_overrun=0.
REQ-034 Reset mid-frame: assert i_reset=0 during data bit 3 -> all outputs 0 at once; the next full frame 0xC3 is received correctly.
